// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default datapath width, ALU and
// multiply/divide operation encodings, the multiply/divide FSM state type
// and small operation-decode helpers.
// No ports (package).
package riscv_pkg;

    localparam int XLEN_DFLT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Encoding follows the M-extension funct3 field.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic md_is_div(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_rem(input muldiv_op_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic md_a_signed(input muldiv_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input muldiv_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One shared add/subtract datapath retires one operand bit per cycle:
// shift-add for multiply, restoring division for divide, both on operand
// magnitudes with the sign fixed up on the final step.
//
// Ports:
//   clk_i     clock, all state on rising edge
//   rst_i     asynchronous active-high reset
//   valid_i   request present          ready_o  unit can accept a request
//   op_i      operation (muldiv_op_t)  a_i/b_i  rs1/rs2 operands
//   flush_i   abort in-flight operation
//   valid_o   result_o valid           ready_i  consumer takes the result
//   result_o  operation result (0 whenever valid_o is 0)
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// BUSY  | iterating, one bit per cycle, counter counts down from XLEN
// DONE  | result held on result_o until ready_i
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DFLT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  muldiv_op_t      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    muldiv_op_t       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  md_q, md_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  res_q, res_d;

    logic             accept;
    logic             last_step;
    logic             in_div;
    logic             in_a_neg, in_b_neg;
    logic [XLEN-1:0]  in_a_mag, in_b_mag;
    logic             div_zero, div_ovf, fast;
    logic [XLEN-1:0]  fast_res;

    logic             cur_div;
    logic [XLEN:0]    shl;
    logic [XLEN:0]    add_a, add_b;
    logic [XLEN+1:0]  sum;
    logic [XLEN-1:0]  hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]  final_res;

    // Incoming operand decode: magnitudes, and the two cases that skip BUSY.
    always_comb begin
        in_div   = md_is_div(op_i);
        in_a_neg = md_a_signed(op_i) && a_i[XLEN-1];
        in_b_neg = md_b_signed(op_i) && b_i[XLEN-1];
        in_a_mag = in_a_neg ? -a_i : a_i;
        in_b_mag = in_b_neg ? -b_i : b_i;
        div_zero = in_div && (b_i == '0);
        div_ovf  = (op_i == MD_DIV || op_i == MD_REM) && (a_i == MOST_NEG) && (&b_i);
        fast     = div_zero || div_ovf;
        fast_res = '0;
        if (div_zero) begin
            fast_res = md_is_rem(op_i) ? a_i : '1;
        end else if (div_ovf) begin
            fast_res = (op_i == MD_DIV) ? MOST_NEG : '0;
        end
    end

    // One iteration of the shared datapath. For divide the adder computes
    // {hi,lo_msb} - divisor; its carry-out is the quotient bit.
    always_comb begin
        cur_div = md_is_div(op_q);
        shl     = {hi_q, lo_q[XLEN-1]};
        if (cur_div) begin
            add_a = shl;
            add_b = ~{1'b0, md_q};
        end else begin
            add_a = {1'b0, hi_q};
            add_b = lo_q[0] ? {1'b0, md_q} : '0;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, cur_div};
        if (cur_div) begin
            hi_n = sum[XLEN+1] ? sum[XLEN-1:0] : shl[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], sum[XLEN+1]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end

        prod     = {hi_n, lo_n};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            MD_MUL:                        final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = neg_q ? -lo_n : lo_n;
            default:                       final_res = neg_q ? -hi_n : hi_n;
        endcase
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ready_o   = (state_q == ST_IDLE) && !rst_i;
        valid_o   = (state_q == ST_DONE);
        accept    = valid_i && ready_o && !flush_i;
        last_step = (state_q == ST_BUSY) && (cnt_q == CNT_ONE);
        case (state_q)
            ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush_i)        state_d = ST_IDLE;
                else if (last_step) state_d = ST_DONE;
            end
            ST_DONE: if (flush_i || ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath register next values.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        neg_d = neg_q;
        md_d  = md_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        res_d = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op_i;
                    neg_d = md_is_rem(op_i) ? in_a_neg : (in_a_neg ^ in_b_neg);
                    md_d  = in_div ? in_b_mag : in_a_mag;
                    lo_d  = in_div ? in_a_mag : in_b_mag;
                    hi_d  = '0;
                    cnt_d = fast ? '0 : CNT_LOAD;
                    res_d = fast ? fast_res : '0;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q - CNT_ONE;
                    if (last_step) res_d = final_res;
                end
            end
            ST_DONE: begin
                if (flush_i || ready_i) res_d = '0;
            end
            default: res_d = '0;
        endcase
    end

    assign result_o = res_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            op_q  <= MD_MUL;
            neg_q <= 1'b0;
            md_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            neg_q <= neg_d;
            md_q  <= md_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv: a table of operations with expected
// result and latency, plus hand-written sequences for back-pressure,
// flush and asynchronous reset.
module tb_riscv_muldiv;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    muldiv_op_t      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    typedef struct {
        string           name;
        muldiv_op_t      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a request at a negedge, let it be accepted, then scramble the
    // inputs so any late sampling of them shows up in the result.
    task automatic start_op(input string name, input muldiv_op_t op,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk_i);
        check({name, " ready_o before accept"}, ready_o, 1);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        op_i    = MD_DIV;
        a_i     = 32'hDEAD_BEEF;
        b_i     = 32'h0;
    endtask

    // Edges counted from the acceptance edge (which is edge 1).
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!valid_o && edges < 100) begin
            @(posedge clk_i);
            edges++;
            @(negedge clk_i);
        end
    endtask

    task automatic retire(input string name);
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        check({name, " valid_o after retire"}, valid_o, 0);
        check({name, " ready_o after retire"}, ready_o, 1);
        check({name, " result_o after retire"}, result_o, 0);
    endtask

    task automatic run_op(input string name, input muldiv_op_t op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_res, input int exp_lat);
        int edges;
        start_op(name, op, a, b);
        wait_valid(edges);
        check({name, " latency"}, edges, exp_lat);
        check({name, " result"}, result_o, exp_res);
        retire(name);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (valid_o) hits++;
        end
        check({name, " valid_o pulses"}, hits, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        logic [XLEN-1:0] held;

        vecs.push_back('{"MUL 7*6",           MD_MUL,    32'd7,          32'd6,          32'd42,         33});
        vecs.push_back('{"MULH min*min",      MD_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33});
        vecs.push_back('{"MULHU max*max",     MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33});
        vecs.push_back('{"DIV -7/2",          MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{"REM -7%2",          MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"DIVU max/2",        MD_DIVU,   32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33});
        vecs.push_back('{"DIV 5/0",           MD_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"REM min%-1",        MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{"DIV min/-1",        MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{"REMU 5%0",          MD_REMU,   32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{"DIVU 7/0",          MD_DIVU,   32'd7,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"MULHSU -1*2",       MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"MUL -1*3",          MD_MUL,    32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  33});
        vecs.push_back('{"DIV 7/-2",          MD_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
        vecs.push_back('{"REM 7%-2",          MD_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{"MULH -3*5",         MD_MULH,   32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"REMU 100%7",        MD_REMU,   32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"MULH maxpos^2",     MD_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF,  33});

        rst_i   = 1'b1;
        valid_i = 1'b0;
        op_i    = MD_MUL;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        ready_i = 1'b0;

        #12;
        check("reset ready_o", ready_o, 0);
        check("reset valid_o", valid_o, 0);
        check("reset result_o", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post-reset ready_o", ready_o, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Back-pressure: hold the result for 5 cycles, then retire while a
        // new request is already offered; it must not be taken that edge.
        start_op("hold", MD_MUL, 32'd7, 32'd6);
        wait_valid(edges);
        check("hold latency", edges, 33);
        held = result_o;
        check("hold first result", held, 42);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("hold valid_o", valid_o, 1);
            check("hold result_o", result_o, held);
        end
        op_i    = MD_MUL;
        a_i     = 32'd3;
        b_i     = 32'd3;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("retire-cycle no accept ready_o", ready_o, 1);
        check("retire-cycle valid_o", valid_o, 0);
        watch_quiet("retire-cycle idle", 3);

        // Flush at BUSY cycle 10.
        start_op("flush busy", MD_MUL, 32'd5, 32'd5);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy ready_o", ready_o, 1);
        check("flush busy valid_o", valid_o, 0);
        watch_quiet("flush busy", 40);

        // Flush in IDLE blocks acceptance.
        @(negedge clk_i);
        op_i    = MD_MUL;
        a_i     = 32'd2;
        b_i     = 32'd2;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush idle ready_o", ready_o, 1);
        watch_quiet("flush idle", 40);

        // Flush in DONE drops the result.
        start_op("flush done", MD_DIV, 32'd9, 32'd0);
        check("flush done valid_o before", valid_o, 1);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush done valid_o", valid_o, 0);
        check("flush done result_o", result_o, 0);
        check("flush done ready_o", ready_o, 1);

        // Reset mid-operation acts without a clock edge.
        start_op("reset busy", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("reset busy ready_o", ready_o, 0);
        check("reset busy valid_o", valid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset busy ready_o after", ready_o, 1);
        watch_quiet("reset busy", 40);

        // Reset while a result is held clears it immediately.
        start_op("reset done", MD_DIVU, 32'd1, 32'd0);
        check("reset done valid_o before", valid_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("reset done valid_o", valid_o, 0);
        check("reset done result_o", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset done ready_o after", ready_o, 1);

        run_op("MUL 3*3 after reset", MD_MUL, 32'd3, 32'd3, 32'd9, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
